// File: rtl/button_gesture_decoder_pkg.sv
// ---------------------------------------------------------------------------
// button_pkg
// Shared types and default timing constants for the push-button gesture
// decoder. Imported by ms_tick_timer and button_gesture_decoder.
//   state_e            : gesture FSM states (3-bit encoding)
//   TICK_DIV_20MHZ     : clock cycles per 1 ms at 20 MHz
//   *_MS_DEF           : default gesture timings in ms
//   max3()             : helper used to size the shared ms counter
// ---------------------------------------------------------------------------
package button_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    PRESS1 = 3'd1,
    GAP    = 3'd2,
    REL2   = 3'd3,
    LONG   = 3'd4
  } state_e;

  localparam int TICK_DIV_20MHZ    = 20000;
  localparam int LONG_MS_DEF       = 800;
  localparam int DOUBLE_GAP_MS_DEF = 250;
  localparam int REPEAT_MS_DEF     = 100;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/button_gesture_decoder_ms_tick_timer.sv
// ---------------------------------------------------------------------------
// ms_tick_timer
// Cycle prescaler producing a 1 ms TICK, and a saturating millisecond
// counter advanced on each TICK. CLR restarts both from zero.
// Ports:
//   CLK    : system clock
//   RST    : synchronous active-high reset
//   CLR    : synchronous restart of prescaler and MS_CNT
//   MS_CNT : elapsed ms since last restart (saturates at all-ones)
//   TICK   : high in the last prescaler cycle of each ms
// ---------------------------------------------------------------------------
module ms_tick_timer
  import button_pkg::*;
#(
  parameter int TICK_DIV = TICK_DIV_20MHZ,
  parameter int MS_W     = 10
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            CLR,
  output logic [MS_W-1:0] MS_CNT,
  output logic            TICK
);

  localparam int PW = $clog2(TICK_DIV);

  logic [PW-1:0] presc;

  assign TICK = (presc == PW'(TICK_DIV - 1));

  // NOTE: reset is sampled on the clock edge only (synchronous); RST and CLR
  // share one priority branch so a restart always beats a pending TICK.
  always_ff @(posedge CLK) begin
    if (RST || CLR) begin
      presc  <= '0;
      MS_CNT <= '0;
    end else if (TICK) begin
      presc <= '0;
      if (MS_CNT != '1) MS_CNT <= MS_CNT + 1'b1;
    end else begin
      presc <= presc + 1'b1;
    end
  end

endmodule

// File: rtl/button_gesture_decoder.sv
// ---------------------------------------------------------------------------
// button_gesture_decoder
// Classifies debounced press/release pulses into short, double and long
// presses, each reported as one registered single-cycle pulse.
// Optional feature macro: BUTTON_AUTO_REPEAT_EN (auto-repeat while long-held).
// Ports:
//   CLK          : system clock (20 MHz nominal)
//   RST          : synchronous active-high reset, aborts any gesture silently
//   BTN_DOWN     : debounced press pulse
//   BTN_UP       : debounced release pulse
//   SHORT_PRESS  : single press, released early, no second press within gap
//   DOUBLE_PRESS : second press within DOUBLE_GAP_MS of the first release
//   LONG_PRESS   : press held for LONG_MS
//   REPEAT       : auto-repeat pulse while long-held (0 without the macro)
//   BUSY         : high while a gesture is in progress
// ---------------------------------------------------------------------------
module button_gesture_decoder
  import button_pkg::*;
#(
  parameter int TICK_DIV      = TICK_DIV_20MHZ,
  parameter int LONG_MS       = LONG_MS_DEF,
  parameter int DOUBLE_GAP_MS = DOUBLE_GAP_MS_DEF,
  parameter int REPEAT_MS     = REPEAT_MS_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic BTN_DOWN,
  input  logic BTN_UP,
  output logic SHORT_PRESS,
  output logic DOUBLE_PRESS,
  output logic LONG_PRESS,
  output logic REPEAT,
  output logic BUSY
);

  localparam int MS_W = $clog2(max3(LONG_MS, DOUBLE_GAP_MS, REPEAT_MS) + 1);

  state_e          state, state_n;
  logic [MS_W-1:0] ms_cnt;
  logic            clr;
  logic            short_n, double_n, long_n;
  // Decisions are made on MS_CNT alone; the raw tick is not needed here.
  logic            tick_unused;

  ms_tick_timer #(
    .TICK_DIV (TICK_DIV),
    .MS_W     (MS_W)
  ) u_timer (
    .CLK    (CLK),
    .RST    (RST),
    .CLR    (clr),
    .MS_CNT (ms_cnt),
    .TICK   (tick_unused)
  );

`ifdef BUTTON_AUTO_REPEAT_EN
  logic repeat_n;
  // A repeat restarts the ms count so the next one is a full period away.
  assign clr = (state_n != state) || repeat_n;
`else
  assign clr = (state_n != state);
  assign REPEAT = 1'b0;
`endif

  // NOTE: every combinational output gets a default first, so no path
  // through the case statement can leave a latch behind.
  always_comb begin
    state_n  = state;
    short_n  = 1'b0;
    double_n = 1'b0;
    long_n   = 1'b0;
`ifdef BUTTON_AUTO_REPEAT_EN
    repeat_n = 1'b0;
`endif
    unique case (state)
      IDLE: begin
        // A stray release (button held through reset) is ignored here.
        if (BTN_DOWN) state_n = PRESS1;
      end
      PRESS1: begin
        // Release beats a same-cycle long timeout.
        if (BTN_UP) begin
          state_n = GAP;
        end else if (ms_cnt == MS_W'(LONG_MS)) begin
          state_n = LONG;
          long_n  = 1'b1;
        end
      end
      GAP: begin
        // A second press beats a same-cycle gap timeout.
        if (BTN_DOWN) begin
          state_n  = REL2;
          double_n = 1'b1;
        end else if (ms_cnt == MS_W'(DOUBLE_GAP_MS)) begin
          state_n = IDLE;
          short_n = 1'b1;
        end
      end
      REL2: begin
        if (BTN_UP) state_n = IDLE;
      end
      LONG: begin
        if (BTN_UP) begin
          state_n = IDLE;
        end
`ifdef BUTTON_AUTO_REPEAT_EN
        else if (ms_cnt == MS_W'(REPEAT_MS)) begin
          repeat_n = 1'b1;
        end
`endif
      end
      default: state_n = IDLE;
    endcase
  end

  // NOTE: state and output registers use non-blocking assignments so every
  // flop samples the pre-edge value of its inputs.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state        <= IDLE;
      SHORT_PRESS  <= 1'b0;
      DOUBLE_PRESS <= 1'b0;
      LONG_PRESS   <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state        <= state_n;
      SHORT_PRESS  <= short_n;
      DOUBLE_PRESS <= double_n;
      LONG_PRESS   <= long_n;
      BUSY         <= (state_n != IDLE);
    end
  end

`ifdef BUTTON_AUTO_REPEAT_EN
  always_ff @(posedge CLK) begin
    if (RST) REPEAT <= 1'b0;
    else     REPEAT <= repeat_n;
  end
`endif

endmodule

// File: tb/tb_button_gesture_decoder.sv
// ---------------------------------------------------------------------------
// tb_button_gesture_decoder
// Self-checking bench for button_gesture_decoder with TICK_DIV=4, LONG_MS=5,
// DOUBLE_GAP_MS=3, REPEAT_MS=2. Each scenario row lists press/release/reset
// cycles and the expected pulse cycles; expected pulses are queued when the
// scenario starts and popped whenever the DUT raises a pulse output.
// Build with +define+BUTTON_AUTO_REPEAT_EN to cover the auto-repeat variant.
// ---------------------------------------------------------------------------
module tb_button_gesture_decoder;

  typedef enum int {K_NONE, K_SHORT, K_DOUBLE, K_LONG, K_REPEAT} kind_e;

  typedef struct {
    string name;
    int    down0, up0, down1, up1, rst_at;
    kind_e k0;
    int    c0;
    int    rep0, rep1;
    int    busy_low;   // -1: BUSY must stay 0 for the whole scenario
    int    len;
  } scen_t;

  typedef struct {
    kind_e kind;
    int    cycle;
  } ev_t;

  logic clk = 1'b0;
  logic rst, btn_down, btn_up;
  logic short_press, double_press, long_press, repeat_p, busy;

  int n_tests = 0;
  int n_fail  = 0;
  ev_t sb[$];
  scen_t scen[7];

  always #5 clk = ~clk;

  button_gesture_decoder #(
    .TICK_DIV      (4),
    .LONG_MS       (5),
    .DOUBLE_GAP_MS (3),
    .REPEAT_MS     (2)
  ) dut (
    .CLK          (clk),
    .RST          (rst),
    .BTN_DOWN     (btn_down),
    .BTN_UP       (btn_up),
    .SHORT_PRESS  (short_press),
    .DOUBLE_PRESS (double_press),
    .LONG_PRESS   (long_press),
    .REPEAT       (repeat_p),
    .BUSY         (busy)
  );

  task automatic check(input string name, input int actual, input int expected);
    n_tests++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // Encoded as kind*1000+cycle so kind and timing are compared together.
  task automatic got_pulse(input string sname, input kind_e k, input int c);
    ev_t e;
    if (sb.size() == 0) begin
      check({sname, " unexpected pulse"}, int'(k) * 1000 + c, 0);
    end else begin
      e = sb.pop_front();
      check({sname, " pulse kind*1000+cycle"}, int'(k) * 1000 + c,
            int'(e.kind) * 1000 + e.cycle);
    end
  endtask

  task automatic push(input kind_e k, input int c);
    ev_t e;
    e.kind  = k;
    e.cycle = c;
    sb.push_back(e);
  endtask

  task automatic run_scen(input scen_t s);
    sb.delete();
    if (s.k0 != K_NONE) push(s.k0, s.c0);
    if (s.rep0 >= 0) push(K_REPEAT, s.rep0);
    if (s.rep1 >= 0) push(K_REPEAT, s.rep1);
    for (int c = 0; c < s.len; c++) begin
      // Outputs seen here are those registered at the edge ending cycle c-1.
      if (short_press)  got_pulse(s.name, K_SHORT, c);
      if (double_press) got_pulse(s.name, K_DOUBLE, c);
      if (long_press)   got_pulse(s.name, K_LONG, c);
      if (repeat_p)     got_pulse(s.name, K_REPEAT, c);
      if (c == 0) check({s.name, " BUSY at start"}, int'(busy), 0);
      if (s.busy_low < 0) begin
        if (c > 0) check({s.name, " BUSY idle"}, int'(busy), 0);
      end else begin
        if (c == s.busy_low - 1) check({s.name, " BUSY before end"}, int'(busy), 1);
        if (c == s.busy_low)     check({s.name, " BUSY at end"}, int'(busy), 0);
      end
      btn_down = (c == s.down0) || (c == s.down1);
      btn_up   = (c == s.up0)   || (c == s.up1);
      rst      = (c == s.rst_at);
      @(posedge clk);
      #1;
    end
    btn_down = 1'b0;
    btn_up   = 1'b0;
    rst      = 1'b0;
    check({s.name, " missing pulses"}, sb.size(), 0);
    check({s.name, " BUSY after"}, int'(busy), 0);
  endtask

  initial begin
    //            name         dn0 up0 dn1 up1 rst  kind      cyc rep0 rep1 blow len
    scen[0] = '{"short",        0, 10, -1, -1, -1, K_SHORT,   24, -1, -1,  24, 40};
    scen[1] = '{"double",       0,  6, 12, 20, -1, K_DOUBLE,  13, -1, -1,  21, 40};
    scen[2] = '{"long",         0, 40, -1, -1, -1, K_LONG,    22, -1, -1,  41, 60};
    scen[3] = '{"up_at_long",   0, 21, -1, -1, -1, K_SHORT,   35, -1, -1,  35, 50};
    scen[4] = '{"down_at_gap",  0, 10, 23, 30, -1, K_DOUBLE,  24, -1, -1,  31, 45};
    scen[5] = '{"rst_in_gap",   0,  6, 20, 25, 12, K_SHORT,   39, -1, -1,  13, 50};
    scen[6] = '{"up_in_idle",  -1,  3, -1, -1, -1, K_NONE,     0, -1, -1,  -1, 15};
`ifdef BUTTON_AUTO_REPEAT_EN
    scen[2].rep0 = 31;
    scen[2].rep1 = 40;
`endif

    rst      = 1'b1;
    btn_down = 1'b0;
    btn_up   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset SHORT_PRESS",  int'(short_press),  0);
    check("reset DOUBLE_PRESS", int'(double_press), 0);
    check("reset LONG_PRESS",   int'(long_press),   0);
    check("reset REPEAT",       int'(repeat_p),     0);
    check("reset BUSY",         int'(busy),         0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 7; i++) begin
      run_scen(scen[i]);
      repeat (3) @(posedge clk);
      #1;
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
